// File: rtl/nios_system_sysid_pkg.sv
// Shared register offsets and CTRL bit positions for the identity/uptime block.
package nios_system_sysid_pkg;
  localparam int NUM_WORDS = 8;

  localparam logic [2:0] OFF_ID      = 3'd0;
  localparam logic [2:0] OFF_TS      = 3'd1;
  localparam logic [2:0] OFF_CAPS    = 3'd2;
  localparam logic [2:0] OFF_SCRATCH = 3'd3;
  localparam logic [2:0] OFF_UP_LO   = 3'd4;
  localparam logic [2:0] OFF_UP_HI   = 3'd5;
  localparam logic [2:0] OFF_TICKS   = 3'd6;
  localparam logic [2:0] OFF_CTRL    = 3'd7;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLEAR  = 1;
endpackage

// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle (no waitrequest, fixed read latency of 1).
interface nios_system_sysid_ext_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle as a tick.
module sysid_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [23:0] LAST = 24'(TICK_DIV - 1);

  logic [23:0] presc_q, presc_d;

  assign tick = en && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr)
      presc_d = '0;
    else if (tick)
      presc_d = '0;
    else if (en)
      presc_d = presc_q + 24'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      presc_q <= '0;
    else
      presc_q <= presc_d;
  end
endmodule

// File: rtl/nios_system_sysid_ext.sv
// Identity and uptime register file: fixed ID words, scratch, 64-bit cycle counter
// with high-word shadow, and a prescaled tick counter.
module nios_system_sysid_ext
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_CAFE,
  parameter logic [31:0] TIMESTAMP = 32'd1524000766,
  parameter logic [7:0]  VERSION   = 8'h02,
  parameter logic [15:0] CLK_MHZ   = 16'd50,
  parameter int          TICK_DIV  = 50000,
  parameter int          ADDR_W    = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  nios_system_sysid_ext_if.slave   bus
);
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ticks_q, ticks_d;
  logic [31:0] shadow_q, shadow_d;
  logic [63:0] cnt_q, cnt_d;
  logic        freeze_q, freeze_d;
  logic        rvalid_q;

  logic [2:0]  word;
  logic        in_map;
  logic        wr_ctrl;
  logic        clr;
  logic        run;
  logic        tick;

  assign word = bus.address[2:0];

  generate
    if (ADDR_W > 3) begin : g_decode_hi
      assign in_map = ~|bus.address[ADDR_W-1:3];
    end else begin : g_decode_full
      assign in_map = 1'b1;
    end
  endgenerate

  assign wr_ctrl = bus.write && in_map && (word == OFF_CTRL) && bus.byteenable[0];
  assign clr     = wr_ctrl && bus.writedata[CTRL_CLEAR];
  assign run     = !freeze_q;

  sysid_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (run),
    .clr     (clr),
    .tick    (tick)
  );

  always_comb begin
    scratch_d = scratch_q;
    if (bus.write && in_map && (word == OFF_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i])
          scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
      end
    end

    freeze_d = wr_ctrl ? bus.writedata[CTRL_FREEZE] : freeze_q;

    // CLEAR takes priority over the increment happening on the same edge.
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + 64'd1;
    else
      cnt_d = cnt_q;

    if (clr)
      ticks_d = '0;
    else if (tick)
      ticks_d = ticks_q + 32'd1;
    else
      ticks_d = ticks_q;

    // Reads sample pre-edge state, so a same-cycle write is not visible yet.
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    if (bus.read) begin
      rdata_d = '0;
      if (in_map) begin
        case (word)
          OFF_ID:      rdata_d = SYSTEM_ID;
          OFF_TS:      rdata_d = TIMESTAMP;
          OFF_CAPS:    rdata_d = {VERSION, 8'(NUM_WORDS), CLK_MHZ};
          OFF_SCRATCH: rdata_d = scratch_q;
          OFF_UP_LO: begin
            rdata_d  = cnt_q[31:0];
            shadow_d = cnt_q[63:32];
          end
          OFF_UP_HI:   rdata_d = shadow_q;
          OFF_TICKS:   rdata_d = ticks_q;
          OFF_CTRL:    rdata_d = {31'd0, freeze_q};
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      ticks_q   <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      freeze_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      ticks_q   <= ticks_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      freeze_q  <= freeze_d;
      rvalid_q  <= bus.read;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;
endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed bench for nios_system_sysid_ext: vector table plus cycle-exact counter sequences.
module tb_nios_system_sysid_ext;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] last_rd;

  nios_system_sysid_ext_if #(.ADDR_W(4)) bus ();

  nios_system_sysid_ext #(
    .SYSTEM_ID (32'h0000_CAFE),
    .TIMESTAMP (32'd1524000766),
    .VERSION   (8'h02),
    .CLK_MHZ   (16'd50),
    .TICK_DIV  (4),
    .ADDR_W    (4)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus cycle: drive at negedge, sample at the following negedge.
  task automatic op(input logic rd, input logic wr, input logic [3:0] a,
                    input logic [31:0] wd, input logic [3:0] be,
                    input logic [31:0] exp, input string name);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = wd;
    bus.byteenable = be;
    @(posedge clk);
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    if (rd) begin
      check({name, " valid"}, {31'd0, bus.readdatavalid}, 32'd1);
      check(name, bus.readdata, exp);
      last_rd = exp;
    end else begin
      check({name, " valid"}, {31'd0, bus.readdatavalid}, 32'd0);
      check({name, " hold"}, bus.readdata, last_rd);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    op(1'b1, 1'b0, a, 32'd0, 4'd0, exp, name);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be, input string name);
    op(1'b0, 1'b1, a, wd, be, 32'd0, name);
  endtask

  // Reset asserted on one negedge, released on the next; first counting edge follows.
  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 32'd0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    last_rd = 32'd0;
    reset_n = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
    bus.writedata = '0; bus.byteenable = '0;

    vecs[0]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0, 32'h0000_CAFE};
    vecs[1]  = '{1'b1, 1'b0, 4'd1,  32'h0,         4'h0, 32'd1524000766};
    vecs[2]  = '{1'b1, 1'b0, 4'd2,  32'h0,         4'h0, 32'h0208_0032};
    vecs[3]  = '{1'b1, 1'b0, 4'd5,  32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 4'd7,  32'h0,         4'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'd3,  32'hA5A5_A5A5, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'd3,  32'h0000_0000, 4'h5, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 32'hA500_A500};
    vecs[8]  = '{1'b0, 1'b1, 4'd0,  32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0, 32'h0000_CAFE};
    vecs[10] = '{1'b0, 1'b1, 4'd11, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 32'hA500_A500};
    vecs[12] = '{1'b1, 1'b0, 4'd8,  32'h0,         4'h0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 4'd3,  32'h1234_5678, 4'hF, 32'hA500_A500};
    vecs[14] = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 32'h1234_5678};
    vecs[15] = '{1'b0, 1'b1, 4'd3,  32'hFFFF_0000, 4'h8, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 32'hFF34_5678};
    vecs[17] = '{1'b0, 1'b1, 4'd7,  32'h0000_0001, 4'hE, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 4'd7,  32'h0,         4'h0, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 4'd14, 32'h0,         4'h0, 32'h0};

    // Reset values while held in reset.
    #2 reset_n = 1'b0;
    #1;
    check("reset readdatavalid", {31'd0, bus.readdatavalid}, 32'd0);
    check("reset readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
         vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Tick/uptime from a fresh reset: after edge k, UP=k and TICKS=k/4.
    pulse_reset();
    repeat (17) @(negedge clk);
    rd(4'd6, 32'd4,  "ticks after 17");
    rd(4'd4, 32'd18, "uplo after 18");
    wr(4'd7, 32'd1, 4'h1, "freeze");
    repeat (20) @(negedge clk);
    rd(4'd6, 32'd5,  "ticks frozen");
    rd(4'd4, 32'd20, "uplo frozen");
    rd(4'd7, 32'd1,  "ctrl freeze");

    // Unfreeze, then CLEAR lands on the prescaler wrap edge.
    wr(4'd7, 32'd0, 4'h1, "unfreeze");
    repeat (3) @(negedge clk);
    wr(4'd7, 32'd2, 4'h1, "clear on wrap");
    rd(4'd6, 32'd0, "ticks cleared");
    rd(4'd4, 32'd1, "uplo restarted");
    rd(4'd7, 32'd0, "ctrl clear reads 0");
    rd(4'd6, 32'd0, "ticks before wrap");
    rd(4'd6, 32'd1, "ticks after wrap");

    wr(4'd7, 32'd3, 4'h1, "clear+freeze");
    rd(4'd4, 32'd0, "uplo clear+freeze");
    rd(4'd7, 32'd1, "ctrl clear+freeze");

    // Carry across 2^32 while a low-word read is in flight.
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.cnt_q;
    @(negedge clk);
    rd(4'd4, 32'hFFFF_FFFF, "uplo preset frozen");
    wr(4'd7, 32'd0, 4'h1, "unfreeze 2");
    rd(4'd4, 32'hFFFF_FFFF, "uplo at carry");
    rd(4'd5, 32'h0,         "uphi at carry");
    rd(4'd4, 32'h1,         "uplo after carry");
    rd(4'd5, 32'h1,         "uphi after carry");
    wr(4'd7, 32'd2, 4'h1, "clear keeps shadow");
    rd(4'd5, 32'h1, "shadow survives clear");
    rd(4'd4, 32'h1, "uplo after clear");

    // Reset while a read response is pending.
    wr(4'd3, 32'h0000_1234, 4'hF, "scratch preset");
    bus.address = 4'd3;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    check("pending valid", {31'd0, bus.readdatavalid}, 32'd1);
    check("pending data", bus.readdata, 32'h0000_1234);
    #1 reset_n = 1'b0;
    #1;
    check("midreset valid", {31'd0, bus.readdatavalid}, 32'd0);
    check("midreset data", bus.readdata, 32'd0);
    bus.read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 32'd0;
    rd(4'd3, 32'd0, "scratch after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
